intbus_initiator: RTL and testbench



---
 rtl/intbus_pkg.sv | 20 ++
 rtl/intbus_interf.sv | 26 ++
 rtl/intbus_rd_timer.sv | 30 +++
 rtl/intbus_initiator.sv | 141 ++++++++++++++
 tb/tb_intbus_initiator.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/intbus_pkg.sv
// Shared definitions for the internal register bus:
// initiator states, error word and hub identification.
package intbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_RD_WAIT,
      ST_RESP
   } intbus_init_state_t;

   localparam logic [31:0] INTBUS_ERR_DATA = 32'hDEADBEEF;
   localparam logic [15:0] HUB_ID = 16'h46E4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/intbus_interf.sv
// Internal register bus: single-cycle wr/rd strobes,
// read data returned later with rvalid.
interface intbus_interf #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 32
) ();

   logic                  clk;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wr;
   logic                  rd;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;

   modport master (
      output clk, addr, wdata, wr, rd,
      input  rdata, rvalid
   );

   modport slave (
      input  clk, addr, wdata, wr, rd,
      output rdata, rvalid
   );

endinterface

// File: rtl/intbus_rd_timer.sv
// Read-window counter: loaded to 1 on start, counts while run,
// flags expired once the count equals TIMEOUT.
module intbus_rd_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic run,
   output logic expired
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= CW'(1);
      end else if (run && !expired) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/intbus_initiator.sv
// Bus master of the internal register bus: turns a valid/ready
// command stream into wr/rd strobes and returns one response each.
module intbus_initiator
   import intbus_pkg::*;
#(
   parameter int                     ADDR_WIDTH = 28,
   parameter int                     DATA_WIDTH = 32,
   parameter int                     TIMEOUT    = 15,
   parameter logic [DATA_WIDTH-1:0]  ERR_DATA   = INTBUS_ERR_DATA
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  stray_rvalid,
   output logic [15:0]           timeout_cnt,
   intbus_interf.master          bus
);

   intbus_init_state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  stray_q;
   logic [15:0]           tcnt_q;

   logic in_rd;
   logic tmr_expired;
   logic rd_hit;
   logic rd_timeout;
   logic accept;

   assign in_rd      = (state_q == ST_RD) || (state_q == ST_RD_WAIT);
   assign rd_hit     = in_rd && bus.rvalid;
   assign rd_timeout = (state_q == ST_RD_WAIT) && !bus.rvalid
                       && tmr_expired;
   assign accept     = (state_q == ST_IDLE) && req_valid;

   intbus_rd_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .resetn  (resetn),
      .start   (state_q == ST_RD),
      .run     (state_q == ST_RD_WAIT),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = req_wr ? ST_WR : ST_RD;
            end
         end
         ST_WR: begin
            state_d = ST_RESP;
         end
         ST_RD: begin
            state_d = bus.rvalid ? ST_RESP : ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (bus.rvalid || tmr_expired) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // rvalid outside a read window is dropped, only flagged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         stray_q <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state_q == ST_WR) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
         if (rd_hit) begin
            rdata_q <= bus.rdata;
            err_q   <= 1'b0;
         end else if (rd_timeout) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            tcnt_q  <= sat_inc16(tcnt_q);
         end
         if (bus.rvalid && !in_rd) begin
            stray_q <= 1'b1;
         end
      end
   end

   assign req_ready    = resetn && (state_q == ST_IDLE);
   assign resp_valid   = (state_q == ST_RESP);
   assign resp_rdata   = rdata_q;
   assign resp_err     = err_q;
   assign stray_rvalid = stray_q;
   assign timeout_cnt  = tcnt_q;

   assign bus.clk   = clk;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;
   assign bus.wr    = (state_q == ST_WR);
   assign bus.rd    = (state_q == ST_RD);

endmodule

// File: tb/tb_intbus_initiator.sv
// Directed bench for intbus_initiator with a hand-driven
// bus slave (rvalid/rdata set per cycle by the stimulus).
module tb_intbus_initiator;
   import intbus_pkg::*;

   localparam int TO = 15;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [27:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stray_rvalid;
   logic [15:0] timeout_cnt;
   logic        sl_rvalid;
   logic [31:0] sl_rdata;
   logic [31:0] hub_word;

   int n_run;
   int n_fail;

   intbus_interf #(
      .ADDR_WIDTH (28),
      .DATA_WIDTH (32)
   ) bus_if ();

   assign bus_if.rvalid = sl_rvalid;
   assign bus_if.rdata  = sl_rdata;

   intbus_initiator #(
      .ADDR_WIDTH (28),
      .DATA_WIDTH (32),
      .TIMEOUT    (TO),
      .ERR_DATA   (32'hDEADBEEF)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .stray_rvalid (stray_rvalid),
      .timeout_cnt  (timeout_cnt),
      .bus          (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr_txn(input logic [27:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = a;
      req_wdata = d;
      chk("wr_rdy", 64'(req_ready), 64'(1));
      @(negedge clk);
      req_valid = 1'b0;
      chk("wr_strobe", 64'(bus_if.wr), 64'(1));
      chk("wr_rd_low", 64'(bus_if.rd), 64'(0));
      chk("wr_addr", 64'(bus_if.addr), 64'(a));
      chk("wr_wdata", 64'(bus_if.wdata), 64'(d));
      chk("wr_no_resp", 64'(resp_valid), 64'(0));
      @(negedge clk);
      chk("wr_pulse", 64'(bus_if.wr), 64'(0));
      chk("wr_resp_v", 64'(resp_valid), 64'(1));
      chk("wr_rdata", 64'(resp_rdata), 64'(0));
      chk("wr_err", 64'(resp_err), 64'(0));
   endtask

   task automatic rd_txn(input logic [27:0] a, input int d,
                         input logic [31:0] dat,
                         input logic [31:0] exp_d,
                         input logic exp_e);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = a;
      chk("rd_rdy", 64'(req_ready), 64'(1));
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_strobe", 64'(bus_if.rd), 64'(1));
      chk("rd_wr_low", 64'(bus_if.wr), 64'(0));
      chk("rd_addr", 64'(bus_if.addr), 64'(a));
      for (int i = 0; i <= TO; i++) begin
         if (i == d) begin
            sl_rvalid = 1'b1;
            sl_rdata  = dat;
         end
         if (i == d || i == TO) begin
            chk("rd_early", 64'(resp_valid), 64'(0));
         end
         @(negedge clk);
         sl_rvalid = 1'b0;
         sl_rdata  = 32'h0;
         if (i == 0) begin
            chk("rd_pulse", 64'(bus_if.rd), 64'(0));
         end
         if (i == d) break;
      end
      chk("rd_resp_v", 64'(resp_valid), 64'(1));
      chk("rd_rdata", 64'(resp_rdata), 64'(exp_d));
      chk("rd_err", 64'(resp_err), 64'(exp_e));
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("ack_idle", 64'(resp_valid), 64'(0));
      chk("ack_rdy", 64'(req_ready), 64'(1));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"}, 64'(req_ready), 64'(0));
      chk({tag, "_rv"}, 64'(resp_valid), 64'(0));
      chk({tag, "_rdata"}, 64'(resp_rdata), 64'(0));
      chk({tag, "_err"}, 64'(resp_err), 64'(0));
      chk({tag, "_stray"}, 64'(stray_rvalid), 64'(0));
      chk({tag, "_tcnt"}, 64'(timeout_cnt), 64'(0));
      chk({tag, "_addr"}, 64'(bus_if.addr), 64'(0));
      chk({tag, "_wdata"}, 64'(bus_if.wdata), 64'(0));
      chk({tag, "_wr"}, 64'(bus_if.wr), 64'(0));
      chk({tag, "_rd"}, 64'(bus_if.rd), 64'(0));
   endtask

   initial begin
      n_run      = 0;
      n_fail     = 0;
      resetn     = 1'b0;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      sl_rvalid  = 1'b0;
      sl_rdata   = '0;
      hub_word   = {16'd3, HUB_ID};

      repeat (2) @(negedge clk);
      chk_zero("rst");
      resetn = 1'b1;
      #1;
      chk("rst_rel_rdy", 64'(req_ready), 64'(1));
      @(negedge clk);

      wr_txn(28'h10, 32'hA5A5A5A5);
      ack();
      chk("addr_hold", 64'(bus_if.addr), 64'(28'h10));
      chk("wdata_hold", 64'(bus_if.wdata), 64'(32'hA5A5A5A5));

      rd_txn(28'h20, 0, 32'h12345678, 32'h12345678, 1'b0);
      ack();
      rd_txn(28'h24, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0);
      ack();
      rd_txn(28'h28, 7, 32'h77777777, 32'h77777777, 1'b0);
      ack();
      rd_txn(28'h2C, TO, 32'h5A5A0F0F, 32'h5A5A0F0F, 1'b0);
      chk("bnd_tcnt", 64'(timeout_cnt), 64'(0));
      ack();
      chk("bnd_stray", 64'(stray_rvalid), 64'(0));

      rd_txn(28'h30, 99, 32'h11111111, 32'hDEADBEEF, 1'b1);
      chk("to_tcnt", 64'(timeout_cnt), 64'(1));
      chk("to_stray0", 64'(stray_rvalid), 64'(0));
      repeat (2) @(negedge clk);
      sl_rvalid = 1'b1;
      sl_rdata  = 32'hBAD0BAD0;
      @(negedge clk);
      sl_rvalid = 1'b0;
      sl_rdata  = 32'h0;
      chk("late_stray", 64'(stray_rvalid), 64'(1));
      chk("late_keep", 64'(resp_rdata), 64'(32'hDEADBEEF));
      ack();
      rd_txn(28'h34, 2, 32'hCAFE0001, 32'hCAFE0001, 1'b0);
      ack();
      chk("after_tcnt", 64'(timeout_cnt), 64'(1));

      wr_txn(28'h40, 32'h01020304);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 28'h44;
      repeat (10) begin
         @(negedge clk);
         chk("bp_rv", 64'(resp_valid), 64'(1));
         chk("bp_rdata", 64'(resp_rdata), 64'(0));
         chk("bp_rdy", 64'(req_ready), 64'(0));
         chk("bp_rd", 64'(bus_if.rd), 64'(0));
         chk("bp_addr", 64'(bus_if.addr), 64'(28'h40));
      end
      req_valid = 1'b0;
      ack();

      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 28'h50;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("mid_rel_rdy", 64'(req_ready), 64'(1));
      repeat (TO + 3) begin
         @(negedge clk);
         chk("mid_no_resp", 64'(resp_valid), 64'(0));
      end
      sl_rvalid = 1'b1;
      sl_rdata  = 32'h99999999;
      @(negedge clk);
      sl_rvalid = 1'b0;
      sl_rdata  = 32'h0;
      chk("mid_stray", 64'(stray_rvalid), 64'(1));
      chk("mid_rv", 64'(resp_valid), 64'(0));

      rd_txn(28'h0, 1, hub_word, 32'h000346E4, 1'b0);
      ack();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
